// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the data-cache miss/write-through controller.
//   state_t    : controller FSM states
//   NB_*       : access size codes seen on cpu_nb / c_nb / mem_nb
//   TIMEOUT_DEF: default number of cycles to wait for mem_ack
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REFILL,
    S_FILL,
    S_RESPOND,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [2:0] NB_B  = 3'b000;
  localparam logic [2:0] NB_H  = 3'b001;
  localparam logic [2:0] NB_W  = 3'b010;
  localparam logic [2:0] NB_BU = 3'b100;
  localparam logic [2:0] NB_HU = 3'b101;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/cache_ctrl_perf.sv
// Saturating read-hit / read-miss event counters.
//   clk, rst_n         : clock, async active-low reset
//   hit_inc, miss_inc  : one-cycle increment strobes
//   hit_cnt, miss_cnt  : counts, stick at all-ones
module cache_ctrl_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit_inc,
  input  logic             miss_inc,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_inc && !(&hit_cnt))   hit_cnt  <= hit_cnt + 1'b1;
      if (miss_inc && !(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Miss/write-through controller between the MEM stage and the data cache.
// Loads go to the cache; read misses refill one aligned word from memory,
// write it into the cache, then re-read it so the cache does the size
// formatting. Stores write the cache and are always forwarded to memory.
//   cpu_*  : pipeline request / result / stall
//   c_*    : cache drive, c_rdata/c_hit combinational from the cache
//   mem_*  : memory request, driven from registered state only
//   hit_cnt, miss_cnt : saturating read hit/miss counts
//   err    : sticky memory-timeout flag
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,  // 1..255
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic [2:0]       cpu_nb,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  output logic             c_rd,
  output logic             c_wr,
  output logic [31:0]      c_addr,
  output logic [31:0]      c_wdata,
  output logic [2:0]       c_nb,
  input  logic [31:0]      c_rdata,
  input  logic             c_hit,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [2:0]       mem_nb,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             err
);

  // Last wait-counter value before giving up; counter starts at 0 on entry.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wcnt;
  logic [31:0] addr_q, wdata_q, fill_q;
  logic [2:0]  nb_q;
  logic        abort_q;
  logic        hit_inc, miss_inc;
  logic        waiting, tmo, accept;

  assign waiting = (state == S_REFILL) || (state == S_WRITE);
  assign tmo     = waiting && !mem_ack && (wcnt == TO_LAST);
  // Latch the request whenever IDLE is about to leave for multi-cycle work.
  assign accept  = (state == S_IDLE) && (cpu_wr || (cpu_rd && !c_hit));

  // Next state and cache/pipeline side. Everything is masked while reset is
  // asserted so the pipeline sees no stall even with a request still held.
  always_comb begin
    state_nxt = state;
    c_rd      = 1'b0;
    c_wr      = 1'b0;
    c_addr    = '0;
    c_wdata   = '0;
    c_nb      = '0;
    cpu_rdata = '0;
    cpu_stall = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    if (rst_n) begin
      case (state)
        S_IDLE: begin
          if (cpu_wr) begin
            c_wr      = 1'b1;
            c_addr    = cpu_addr;
            c_wdata   = cpu_wdata;
            c_nb      = cpu_nb;
            cpu_stall = 1'b1;
            state_nxt = S_WRITE;
          end else if (cpu_rd) begin
            c_rd   = 1'b1;
            c_addr = cpu_addr;
            c_nb   = cpu_nb;
            if (c_hit) begin
              cpu_rdata = c_rdata;
              hit_inc   = 1'b1;
            end else begin
              cpu_stall = 1'b1;
              miss_inc  = 1'b1;
              state_nxt = S_REFILL;
            end
          end
        end
        S_REFILL: begin
          cpu_stall = 1'b1;
          if (mem_ack)  state_nxt = S_FILL;
          else if (tmo) state_nxt = S_RESPOND;
        end
        S_FILL: begin
          cpu_stall = 1'b1;
          c_wr      = 1'b1;
          c_addr    = {addr_q[31:2], 2'b00};
          c_wdata   = fill_q;
          c_nb      = NB_W;
          state_nxt = S_RESPOND;
        end
        S_RESPOND: begin
          // Re-read through the cache so it formats the sub-word result.
          c_rd      = 1'b1;
          c_addr    = addr_q;
          c_nb      = nb_q;
          cpu_rdata = abort_q ? 32'h0 : c_rdata;
          state_nxt = S_IDLE;
        end
        S_WRITE: begin
          cpu_stall = 1'b1;
          if (mem_ack || tmo) state_nxt = S_DONE;
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Memory side: registered state and latches only.
  always_comb begin
    mem_req   = waiting;
    mem_we    = (state == S_WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_nb    = '0;
    if (state == S_REFILL) begin
      mem_addr = {addr_q[31:2], 2'b00};
      mem_nb   = NB_W;
    end else if (state == S_WRITE) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_nb    = nb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      nb_q    <= '0;
      fill_q  <= '0;
      abort_q <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= (waiting && state_nxt == state) ? wcnt + 8'd1 : 8'd0;
      if (accept) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        nb_q    <= cpu_nb;
        abort_q <= 1'b0;
      end
      if (state == S_REFILL && mem_ack) fill_q <= mem_rdata;
      if (tmo) begin
        err <= 1'b1;
        if (state == S_REFILL) abort_q <= 1'b1;
      end
    end
  end

  cache_ctrl_perf #(.CNT_W(CNT_W)) u_perf (
    .clk      (clk),
    .rst_n    (rst_n),
    .hit_inc  (hit_inc),
    .miss_inc (miss_inc),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: small behavioural cache and memory responder,
// expected load results queued at issue and compared on retirement.
module tb_cache_ctrl;
  import cache_ctrl_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [2:0]  cpu_nb = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        c_rd, c_wr;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [2:0]  c_nb;
  logic        c_hit;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_nb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] hit_cnt, miss_cnt;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  cache_ctrl #(.TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_nb(cpu_nb), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .c_rd(c_rd), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_nb(c_nb), .c_rdata(c_rdata), .c_hit(c_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_nb(mem_nb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .err(err)
  );

  // ---------------- cache model (word-indexed by addr[15:2]) ----------------
  logic [31:0] cmem [16384];
  bit          cv   [16384];
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = '0, pre_data = '0;
  logic [31:0] cw;

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] off,
                                      input logic [2:0] nb);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (nb)
      NB_B:    return {{24{b[7]}}, b};
      NB_BU:   return {24'h0, b};
      NB_H:    return {{16{h[15]}}, h};
      NB_HU:   return {16'h0, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    c_hit   = 1'b0;
    c_rdata = '0;
    cw      = cmem[c_addr[15:2]];
    if (c_rd && cv[c_addr[15:2]]) begin
      c_hit   = 1'b1;
      c_rdata = fmt(cw, c_addr[1:0], c_nb);
    end
  end

  always @(posedge clk) begin
    if (pre_we) begin
      cmem[pre_addr[15:2]] <= pre_data;
      cv[pre_addr[15:2]]   <= 1'b1;
    end else if (c_wr) begin
      if (c_nb == NB_W) begin
        cmem[c_addr[15:2]] <= c_wdata;
        cv[c_addr[15:2]]   <= 1'b1;
      end else if (cv[c_addr[15:2]]) begin
        if (c_nb[0]) cmem[c_addr[15:2]][16*c_addr[1] +: 16] <= c_wdata[15:0];
        else         cmem[c_addr[15:2]][8*c_addr[1:0] +: 8] <= c_wdata[7:0];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one load/store, act as memory (ack on the lat-th request cycle,
  // lat=0 never acks), and check stall length, memory request contents,
  // cache write count and, for loads, the queued result.
  task automatic run_op(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] nb, input int lat,
                        input logic [31:0] md, input logic [31:0] exp_rd,
                        input int exp_stall, input int exp_req, input int exp_cwr);
    int stalls = 0, reqs = 0, cwr = 0;
    bit done = 0;
    logic [31:0] exp_ma;
    exp_ma = wr ? addr : {addr[31:2], 2'b00};
    if (!wr) exp_q.push_back(exp_rd);
    cpu_wr = wr; cpu_rd = !wr; cpu_addr = addr; cpu_wdata = wd; cpu_nb = nb;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      if (mem_req) begin
        reqs++;
        chk({tag, ":mem_addr"}, mem_addr, exp_ma);
        chk({tag, ":mem_we"}, 32'(mem_we), 32'(wr));
        chk({tag, ":mem_nb"}, 32'(mem_nb), 32'(wr ? nb : NB_W));
        if (wr) chk({tag, ":mem_wdata"}, mem_wdata, wd);
        mem_ack   = (reqs == lat);
        mem_rdata = md;
      end
      if (c_wr) begin
        cwr++;
        if (wr) chk({tag, ":c_nb_wr"}, 32'(c_nb), 32'(nb));
      end
      if (!cpu_stall) begin
        done = 1;
        if (!wr) begin
          chk({tag, ":rdata"}, cpu_rdata, exp_q.pop_front());
          chk({tag, ":c_rd_nb"}, {28'h0, c_rd, c_nb}, {28'h0, 1'b1, nb});
        end
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1 mem_ack = 1'b0;
    end
    if (!done) chk({tag, ":retire_timeout"}, 32'd0, 32'd1);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    chk({tag, ":stall_cycles"}, stalls, exp_stall);
    chk({tag, ":mem_req_cycles"}, reqs, exp_req);
    chk({tag, ":c_wr_pulses"}, cwr, exp_cwr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with the hit line preloaded.
    pre_we = 1'b1; pre_addr = 32'h0000_1004; pre_data = 32'hDEADBEEF;
    @(posedge clk); #1 pre_we = 1'b0;
    @(negedge clk);
    chk("rst:stall", 32'(cpu_stall), 32'd0);
    chk("rst:mem_req", 32'(mem_req), 32'd0);
    chk("rst:rdata", cpu_rdata, 32'd0);
    chk("rst:cnts", hit_cnt | miss_cnt, 32'd0);
    chk("rst:err", 32'(err), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_op("lw_hit", 0, 32'h0000_1004, 0, NB_W, 0, 0, 32'hDEADBEEF, 0, 0, 0);
    chk("lw_hit:hit_cnt", hit_cnt, 32'd1);

    run_op("lw_miss", 0, 32'h0000_2008, 0, NB_W, 3, 32'h12345678, 32'h12345678, 5, 3, 1);
    chk("lw_miss:miss_cnt", miss_cnt, 32'd1);
    chk("lw_miss:hit_cnt", hit_cnt, 32'd1);

    run_op("lw_rehit", 0, 32'h0000_2008, 0, NB_W, 0, 0, 32'h12345678, 0, 0, 0);
    chk("lw_rehit:hit_cnt", hit_cnt, 32'd2);

    run_op("sb", 1, 32'h0000_3001, 32'h0000_00AB, NB_B, 2, 0, 0, 3, 2, 1);

    run_op("lb_miss", 0, 32'h0000_4000, 0, NB_B, 1, 32'h0000_0080, 32'hFFFF_FF80, 3, 1, 1);
    chk("lb_miss:miss_cnt", miss_cnt, 32'd2);

    run_op("lw_tmo", 0, 32'h0000_5000, 0, NB_W, 0, 32'hCAFE_F00D, 32'h0, 1 + TMO, TMO, 0);
    chk("lw_tmo:err", 32'(err), 32'd1);
    chk("lw_tmo:miss_cnt", miss_cnt, 32'd3);
    @(negedge clk);
    chk("lw_tmo:idle_req", 32'(mem_req), 32'd0);
    chk("lw_tmo:idle_stall", 32'(cpu_stall), 32'd0);

    // Reset in the middle of a store's memory wait.
    @(posedge clk); #1;
    cpu_wr = 1'b1; cpu_addr = 32'h0000_6000; cpu_wdata = 32'h0000_0011; cpu_nb = NB_W;
    @(negedge clk);
    @(negedge clk);
    chk("rstw:in_write", {30'h0, mem_req, mem_we}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw:mem_req", 32'(mem_req), 32'd0);
    chk("rstw:stall", 32'(cpu_stall), 32'd0);
    chk("rstw:cnts", hit_cnt | miss_cnt, 32'd0);
    chk("rstw:err", 32'(err), 32'd0);
    cpu_wr = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    chk("stale_ack:mem_req", 32'(mem_req), 32'd0);
    chk("stale_ack:stall", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    chk("stale_ack:idle", {29'h0, mem_req, cpu_stall, err}, 32'd0);
    @(posedge clk); #1;

    run_op("post_rst_hit", 0, 32'h0000_1004, 0, NB_W, 0, 0, 32'hDEADBEEF, 0, 0, 0);
    chk("post_rst_hit:hit_cnt", hit_cnt, 32'd1);
    chk("scoreboard:empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Miss/write-through controller that sequences the pipeline's tagged data cache (`cachemem`) against a slower main-memory port.
- Sits between the MEM stage and the cache.
- Forwards every load/store to the cache and resolves read misses by refill from memory.
- Propagates every store to memory (write-through).
- Stalls the pipeline for all multi-cycle work.
- Keeps hit/miss counters and a sticky memory-timeout error.

## Interface
Parameters:
- `TIMEOUT`, 255: max cycles waiting for `mem_ack` before abort.
- `CNT_W`, 32: width of hit/miss counters.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cpu_rd`, `cpu_wr` in 1: load / store request; held stable while `cpu_stall`=1.
- `cpu_addr` in 32, `cpu_wdata` in 32, `cpu_nb` in 3: access address, store data, size code (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `cpu_rdata` out 32: load result, valid when `cpu_stall`=0.
- `cpu_stall` out 1: freeze pipeline.
- `c_rd`, `c_wr` out 1; `c_addr` out 32; `c_wdata` out 32; `c_nb` out 3: cache drive.
- `c_rdata` in 32; `c_hit` in 1: cache read data and combinational hit.
- `mem_req` out 1; `mem_we` out 1; `mem_addr` out 32; `mem_wdata` out 32; `mem_nb` out 3: memory request.
- `mem_ack` in 1; `mem_rdata` in 32: memory completion.
- `hit_cnt`, `miss_cnt` out CNT_W: read hit / read miss counts.
- `err` out 1: sticky timeout flag.

## Operation
States: IDLE, REFILL, FILL, RESPOND, WRITE, DONE.

- **IDLE, `cpu_wr`=1** (wins over `cpu_rd`):
  - `c_wr`=1 for this cycle only, with `cpu_nb`/`cpu_addr`/`cpu_wdata`; `cpu_stall`=1.
  - Latch addr/data/nb; go to WRITE.
- **IDLE, `cpu_rd`=1:**
  - `c_rd`=1 with `cpu_addr`/`cpu_nb`.
  - `c_hit`=1: `cpu_rdata`=`c_rdata`, `cpu_stall`=0, `hit_cnt`++; stay IDLE.
  - `c_hit`=0: `cpu_stall`=1, `miss_cnt`++, latch request, go to REFILL.
- **IDLE, no request:** all strobes 0, `cpu_stall`=0.
- **REFILL:**
  - `mem_req`=1, `mem_we`=0, `mem_nb`=010, `mem_addr`={addr[31:2],2'b00}.
  - On `mem_ack`: capture `mem_rdata`, go to FILL.
- **FILL:** `c_wr`=1, `c_nb`=010, captured word to aligned address (one cycle); go to RESPOND.
- **RESPOND:**
  - `c_rd`=1 with latched addr/nb; `cpu_rdata`=`c_rdata`; `cpu_stall`=0; go to IDLE.
  - `hit_cnt` not incremented.
- **WRITE:**
  - `mem_req`=1, `mem_we`=1, latched addr/data/nb on `mem_*`.
  - On `mem_ack`: go to DONE.
- **DONE:** `cpu_stall`=0, no strobes; go to IDLE. The still-present store is retired, not reissued.
- **Timeout:**
  - An 8-bit wait counter runs in REFILL/WRITE and clears on state entry.
  - On reaching TIMEOUT without ack: drop `mem_req`, set `err`.
  - REFILL aborts to RESPOND with `cpu_rdata`=0 and no FILL. WRITE aborts to DONE.
- **Ignored inputs:**
  - `mem_ack` outside REFILL/WRITE.
  - `cpu_*` changes outside IDLE.
- **Counters:** saturate at all-ones.
- **`err`:** cleared only by reset.

## Timing
- Reset (async assert, sync deassert use): state IDLE, all strobes 0, `cpu_stall`=0, `cpu_rdata`=0, counters 0, `err`=0, latches 0.
- Reset mid-REFILL/WRITE drops `mem_req` immediately.
- `c_*` and `cpu_stall` are combinational from state plus `cpu_*`/`c_hit`.
- `mem_*` are registered-state-derived only, with no combinational path from `cpu_*`.
- Read hit: 0 stall cycles.
- Read miss: stall = 1 (IDLE) + N (REFILL incl. ack cycle) + 1 (FILL); data returned in RESPOND. Total N+3 cycles.
- Store: stall = 1 (IDLE) + N (WRITE); completes in DONE. Total N+2 cycles.
- `mem_req` is held high with stable address/data until the `mem_ack` cycle inclusive; `mem_ack` is sampled on `clk` rising edge.
- A back-to-back request is accepted in the cycle after RESPOND/DONE.

## Structure
- `cache_ctrl_pkg`:
  - State enum.
  - Nb codes NB_B, NB_H, NB_W, NB_BU, NB_HU.
  - Default TIMEOUT.
- Sub-module `cache_ctrl_perf`: saturating `hit_cnt`/`miss_cnt` with increment strobes and async active-low reset.

## Test plan
- Reset then lw 0x0000_1004, cache preloaded with tag hit, data 0xDEADBEEF → `cpu_rdata`=0xDEADBEEF same cycle, `cpu_stall`=0, `hit_cnt`=1.
- lw 0x0000_2008 miss, `mem_ack` after 3 cycles with 0x12345678:
  - `mem_addr`=0x0000_2008, `cpu_stall` high 5 cycles.
  - RESPOND returns 0x12345678; `miss_cnt`=1.
  - Repeated lw hits.
- sb 0x0000_3001 data 0xAB:
  - One `c_wr` pulse with `c_nb`=000.
  - `mem_we`=1, `mem_nb`=000, `mem_wdata`=0x…AB until ack.
  - DONE deasserts stall, no second cache write.
- lb 0x0000_4000 miss whose refilled word is 0x00000080 → RESPOND uses `c_nb`=000, `cpu_rdata` as cache formats it.
- No `mem_ack` for TIMEOUT=4 on a load → `mem_req` drops after 4 cycles, `err`=1, `cpu_rdata`=0, FSM back to IDLE.
- Assert `rst_n`=0 mid-WRITE → `mem_req`=0 and `cpu_stall`=0 immediately, counters 0; a stale `mem_ack` after release is ignored.
